// File: rtl/writeback_arbiter_if.sv
// Writeback bus: ALU and memory writeback requests in, register-file write
// port and in-flight status out.
interface writeback_arbiter_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 4,
  parameter int unsigned DW    = 24
);
  logic                     alu_wb_valid;
  logic [AW-1:0]            alu_wb_dest;
  logic [DW-1:0]            alu_wb_data;
  logic                     mem_wb_valid;
  logic                     mem_wb_ready;
  logic [AW-1:0]            mem_wb_dest;
  logic [DW-1:0]            mem_wb_data;
  logic                     reg_write_en;
  logic [AW-1:0]            reg_write_dest;
  logic [DW-1:0]            reg_write_data;
  logic [(2**AW)-1:0]       pending_mask;
  logic [$clog2(DEPTH):0]   fifo_count;

  // Writeback sources / register file side
  modport master (
    output alu_wb_valid, alu_wb_dest, alu_wb_data,
    output mem_wb_valid, mem_wb_dest, mem_wb_data,
    input  mem_wb_ready,
    input  reg_write_en, reg_write_dest, reg_write_data,
    input  pending_mask, fifo_count
  );

  // Arbiter side
  modport slave (
    input  alu_wb_valid, alu_wb_dest, alu_wb_data,
    input  mem_wb_valid, mem_wb_dest, mem_wb_data,
    output mem_wb_ready,
    output reg_write_en, reg_write_dest, reg_write_data,
    output pending_mask, fifo_count
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Merges the never-stalling ALU writeback and the FIFO-buffered memory
// writeback onto the single register-file write port. Queued memory writes
// overtaken by a younger ALU write to the same register are squashed.
module writeback_arbiter #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 4,
  parameter int unsigned DW    = 24
) (
  input  logic              clk,
  input  logic              rst,
  writeback_arbiter_if.slave wb
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned NR = 2 ** AW;

  logic [AW-1:0]    dest_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PW-1:0]    rptr_q, wptr_q;
  logic [CW-1:0]    count_q, count_d;

  logic             wr_en_q, wr_en_d;
  logic [AW-1:0]    wr_dest_q, wr_dest_d;
  logic [DW-1:0]    wr_data_q, wr_data_d;

  logic             ready, accept, alu_go, mem_nz, empty, head_vld;
  logic             pop, push, bypass;
  logic [NR-1:0]    pend;

  // Arbitration, FIFO control and next write-port contents
  always_comb begin
    ready    = (count_q < CW'(DEPTH));
    accept   = wb.mem_wb_valid && ready;
    mem_nz   = (wb.mem_wb_dest != '0);
    alu_go   = wb.alu_wb_valid && (wb.alu_wb_dest != '0);
    empty    = (count_q == '0);
    head_vld = !empty && vld_q[rptr_q];
    // A squashed head drains even while the ALU owns the port
    pop      = !empty && (!head_vld || !alu_go);
    bypass   = !alu_go && empty && accept && mem_nz;
    push     = accept && mem_nz && !bypass;
    count_d  = count_q + CW'(push) - CW'(pop);

    wr_en_d   = 1'b0;
    wr_dest_d = wr_dest_q;
    wr_data_d = wr_data_q;
    if (alu_go) begin
      wr_en_d   = 1'b1;
      wr_dest_d = wb.alu_wb_dest;
      wr_data_d = wb.alu_wb_data;
    end else if (head_vld) begin
      wr_en_d   = 1'b1;
      wr_dest_d = dest_q[rptr_q];
      wr_data_d = data_q[rptr_q];
    end else if (bypass) begin
      wr_en_d   = 1'b1;
      wr_dest_d = wb.mem_wb_dest;
      wr_data_d = wb.mem_wb_data;
    end
  end

  // Registers with writes still in flight (queued or on the port now)
  always_comb begin
    pend = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (vld_q[i]) pend[dest_q[i]] = 1'b1;
    end
    if (wr_en_q) pend[wr_dest_q] = 1'b1;
  end

  // FIFO state and registered write port
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q     <= '0;
      rptr_q    <= '0;
      wptr_q    <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_dest_q <= '0;
      wr_data_q <= '0;
    end else begin
      // Squash first so a same-cycle push to the same register survives
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (alu_go && (dest_q[i] == wb.alu_wb_dest)) vld_q[i] <= 1'b0;
      end
      if (pop) begin
        vld_q[rptr_q] <= 1'b0;
        rptr_q        <= rptr_q + PW'(1);
      end
      if (push) begin
        vld_q[wptr_q] <= 1'b1;
        wptr_q        <= wptr_q + PW'(1);
      end
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      wr_dest_q <= wr_dest_d;
      wr_data_q <= wr_data_d;
    end
  end

  // FIFO payload storage
  always_ff @(posedge clk) begin
    if (push) begin
      dest_q[wptr_q] <= wb.mem_wb_dest;
      data_q[wptr_q] <= wb.mem_wb_data;
    end
  end

  assign wb.mem_wb_ready   = ready;
  assign wb.reg_write_en   = wr_en_q;
  assign wb.reg_write_dest = wr_dest_q;
  assign wb.reg_write_data = wr_data_q;
  assign wb.pending_mask   = pend;
  assign wb.fifo_count     = count_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: reset, bypass, ALU priority,
// back-pressure with pointer wrap, squash, r0 handling and mid-run reset.
module tb_writeback_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   passed = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  writeback_arbiter_if #(.DEPTH(4), .AW(4), .DW(24)) wb ();

  writeback_arbiter #(.DEPTH(4), .AW(4), .DW(24)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wb)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_alu(input logic v, input logic [3:0] d, input logic [23:0] x);
    wb.alu_wb_valid = v;
    wb.alu_wb_dest  = d;
    wb.alu_wb_data  = x;
  endtask

  task automatic set_mem(input logic v, input logic [3:0] d, input logic [23:0] x);
    wb.mem_wb_valid = v;
    wb.mem_wb_dest  = d;
    wb.mem_wb_data  = x;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic [3:0] d, input logic [23:0] x);
    chk({tag, "_en"}, 32'(wb.reg_write_en), 32'd1);
    chk({tag, "_dest"}, 32'(wb.reg_write_dest), 32'(d));
    chk({tag, "_data"}, 32'(wb.reg_write_data), 32'(x));
  endtask

  initial begin
    set_alu(0, 0, 0);
    set_mem(0, 0, 0);

    // Reset then idle
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    settle();
    chk("rst_en", 32'(wb.reg_write_en), 32'd0);
    chk("rst_pend", 32'(wb.pending_mask), 32'h0);
    chk("rst_ready", 32'(wb.mem_wb_ready), 32'd1);
    chk("rst_count", 32'(wb.fifo_count), 32'd0);
    tick();
    chk("idle_en", 32'(wb.reg_write_en), 32'd0);

    // Bypass: empty FIFO, memory write goes straight to the port
    set_mem(1, 3, 24'h1CAC5);
    settle();
    chk("byp_ready", 32'(wb.mem_wb_ready), 32'd1);
    tick();
    set_mem(0, 0, 0);
    chk_wr("byp", 4'd3, 24'h1CAC5);
    chk("byp_count", 32'(wb.fifo_count), 32'd0);
    chk("byp_pend", 32'(wb.pending_mask), 32'h0008);
    tick();
    chk("byp_idle", 32'(wb.reg_write_en), 32'd0);

    // ALU priority; memory write queued behind it
    set_alu(1, 1, 24'h01000);
    set_mem(1, 4, 24'h3858C);
    tick();
    set_alu(0, 0, 0);
    set_mem(0, 0, 0);
    chk_wr("pri_alu", 4'd1, 24'h01000);
    chk("pri_count1", 32'(wb.fifo_count), 32'd1);
    chk("pri_pend1", 32'(wb.pending_mask), 32'h0012);
    tick();
    chk_wr("pri_mem", 4'd4, 24'h3858C);
    chk("pri_count2", 32'(wb.fifo_count), 32'd0);
    chk("pri_pend2", 32'(wb.pending_mask), 32'h0010);
    tick();
    chk("pri_idle", 32'(wb.reg_write_en), 32'd0);
    chk("pri_pend3", 32'(wb.pending_mask), 32'h0);

    // Full / back-pressure with ALU hogging the port
    set_alu(1, 2, 24'h00222);
    for (int i = 5; i <= 8; i++) begin
      set_mem(1, 4'(i), 24'hA0000 | 24'(i));
      settle();
      chk("full_ready_acc", 32'(wb.mem_wb_ready), 32'd1);
      tick();
      chk_wr("full_alu", 4'd2, 24'h00222);
      chk("full_count", 32'(wb.fifo_count), 32'(i - 4));
    end
    chk("full_pend", 32'(wb.pending_mask), 32'h01E4);
    set_mem(1, 9, 24'hA0009);
    settle();
    chk("full_ready0", 32'(wb.mem_wb_ready), 32'd0);
    tick();
    chk("full_hold", 32'(wb.fifo_count), 32'd4);
    set_alu(0, 0, 0);
    settle();
    chk("full_ready0b", 32'(wb.mem_wb_ready), 32'd0);
    tick();
    chk_wr("drain5", 4'd5, 24'hA0005);
    chk("drain5_cnt", 32'(wb.fifo_count), 32'd3);
    settle();
    chk("drain_ready", 32'(wb.mem_wb_ready), 32'd1);
    tick();
    set_mem(1, 10, 24'hA000A);
    chk_wr("drain6", 4'd6, 24'hA0006);
    chk("drain6_cnt", 32'(wb.fifo_count), 32'd3);
    tick();
    set_mem(0, 0, 0);
    chk_wr("drain7", 4'd7, 24'hA0007);
    chk("drain7_cnt", 32'(wb.fifo_count), 32'd3);
    tick();
    chk_wr("drain8", 4'd8, 24'hA0008);
    chk("drain8_cnt", 32'(wb.fifo_count), 32'd2);
    tick();
    chk_wr("drain9", 4'd9, 24'hA0009);
    chk("drain9_cnt", 32'(wb.fifo_count), 32'd1);
    tick();
    chk_wr("drain10", 4'd10, 24'hA000A);
    chk("drain10_cnt", 32'(wb.fifo_count), 32'd0);
    tick();
    chk("drain_idle", 32'(wb.reg_write_en), 32'd0);

    // Squash: queued r6 overtaken by ALU r6
    set_alu(1, 1, 24'h00111);
    set_mem(1, 6, 24'hAAAAA);
    tick();
    set_mem(0, 0, 0);
    chk_wr("sq_alu1", 4'd1, 24'h00111);
    chk("sq_count1", 32'(wb.fifo_count), 32'd1);
    chk("sq_pend1", 32'(wb.pending_mask), 32'h0042);
    set_alu(1, 6, 24'h3EFFF);
    tick();
    set_alu(0, 0, 0);
    chk_wr("sq_alu6", 4'd6, 24'h3EFFF);
    chk("sq_count2", 32'(wb.fifo_count), 32'd1);
    chk("sq_pend2", 32'(wb.pending_mask), 32'h0040);
    tick();
    chk("sq_pop_en", 32'(wb.reg_write_en), 32'd0);
    chk("sq_count3", 32'(wb.fifo_count), 32'd0);
    chk("sq_pend3", 32'(wb.pending_mask), 32'h0);
    tick();
    chk("sq_idle", 32'(wb.reg_write_en), 32'd0);

    // Zero register: both sources target r0
    set_alu(1, 0, 24'h00123);
    set_mem(1, 0, 24'h00456);
    settle();
    chk("r0_ready", 32'(wb.mem_wb_ready), 32'd1);
    tick();
    set_alu(0, 0, 0);
    set_mem(0, 0, 0);
    chk("r0_en", 32'(wb.reg_write_en), 32'd0);
    chk("r0_count", 32'(wb.fifo_count), 32'd0);
    chk("r0_pend", 32'(wb.pending_mask), 32'h0);

    // Mid-operation reset with three entries queued
    set_alu(1, 2, 24'h00222);
    set_mem(1, 7, 24'hB0007);
    tick();
    set_mem(1, 8, 24'hB0008);
    tick();
    set_mem(1, 9, 24'hB0009);
    tick();
    chk("mr_count3", 32'(wb.fifo_count), 32'd3);
    chk("mr_pend", 32'(wb.pending_mask), 32'h0384);
    rst = 1'b1;
    set_alu(0, 0, 0);
    set_mem(0, 0, 0);
    tick();
    rst = 1'b0;
    chk("mr_en", 32'(wb.reg_write_en), 32'd0);
    chk("mr_count", 32'(wb.fifo_count), 32'd0);
    chk("mr_pend0", 32'(wb.pending_mask), 32'h0);
    chk("mr_ready", 32'(wb.mem_wb_ready), 32'd1);
    tick();
    chk("mr_en2", 32'(wb.reg_write_en), 32'd0);
    chk("mr_count2", 32'(wb.fifo_count), 32'd0);
    tick();
    chk("mr_en3", 32'(wb.reg_write_en), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
